// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter: select codes, FSM states,
// one-hot grant patterns and the select-to-grant decode.
package mux_rr_arbiter_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam logic [3:0] GNT_NONE = 4'b0000;
  localparam logic [3:0] GNT_A    = 4'b0001;
  localparam logic [3:0] GNT_B    = 4'b0010;
  localparam logic [3:0] GNT_C    = 4'b0100;
  localparam logic [3:0] GNT_D    = 4'b1000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [3:0] sel_to_gnt(input logic [1:0] sel);
    logic [3:0] g;
    case (sel)
      SEL_A:   g = GNT_A;
      SEL_B:   g = GNT_B;
      SEL_C:   g = GNT_C;
      default: g = GNT_D;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4to1.sv
// Combinational 4->1 data mux steered by the arbiter's select.
module mux4to1
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] in0_i,
  input  logic [DATA_WIDTH-1:0] in1_i,
  input  logic [DATA_WIDTH-1:0] in2_i,
  input  logic [DATA_WIDTH-1:0] in3_i,
  input  logic [1:0]            sel_i,
  output logic [DATA_WIDTH-1:0] out_o
);

  always_comb begin
    out_o = in0_i;
    case (sel_i)
      SEL_A:   out_o = in0_i;
      SEL_B:   out_o = in1_i;
      SEL_C:   out_o = in2_i;
      SEL_D:   out_o = in3_i;
      default: out_o = in0_i;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one output channel between four sources; a grant
// lasts until last, MAX_BEATS beats, or withdrawal of the granted request.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            last,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_c,
  input  logic [DATA_WIDTH-1:0] in_d,
  input  logic                  out_ready,
  output logic [3:0]            gnt,
  output logic [1:0]            mux_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  dbg_state,
  output logic [$clog2(MAX_BEATS+1)-1:0] dbg_beat_cnt
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  // Consumer handshake: out_valid is high while granted and the owner still
  // requests; a beat transfers when out_valid and out_ready are both high.
  arb_state_e      state_q;
  logic [3:0]      gnt_q;
  logic [1:0]      sel_q;
  logic [1:0]      ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            beat;
  logic            owner_req;
  logic            release_burst;

  // First requester after the pointer wins; the pointer itself is lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    win = p;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign busy          = (state_q == ST_GRANT);
  assign owner_req     = req[sel_q];
  assign out_valid     = busy & owner_req;
  assign beat          = out_valid & out_ready;
  assign release_burst = !owner_req
                       || (beat && (last[sel_q] || cnt_q == CW'(MAX_BEATS - 1)));
  assign gnt           = gnt_q;
  assign mux_sel       = sel_q;
  assign dbg_state     = state_q;
  assign dbg_beat_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
      sel_q   <= SEL_A;
      ptr_q   <= SEL_D;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            sel_q   <= rr_pick(req, ptr_q);
            ptr_q   <= rr_pick(req, ptr_q);
            gnt_q   <= sel_to_gnt(rr_pick(req, ptr_q));
            cnt_q   <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (beat) cnt_q <= cnt_q + CW'(1);
          if (release_burst) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= GNT_NONE;
        end
      endcase
    end
  end

  mux4to1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .in0_i (in_a),
    .in1_i (in_b),
    .in2_i (in_c),
    .in3_i (in_d),
    .sel_i (sel_q),
    .out_o (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a burst-level reference model via an expected queue.
module tb_mux_rr_arbiter;

  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b1111;
  logic [3:0]    last = 4'b0000;
  logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic          out_ready = 1'b0;
  logic [3:0]    gnt;
  logic [1:0]    mux_sel;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          dbg_state;
  logic [CW-1:0] dbg_beat_cnt;

  mux_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_ready(out_ready), .gnt(gnt), .mux_sel(mux_sel),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic          busy;
    logic [DW-1:0] data;
    logic [CW-1:0] beats;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the channel, how many beats it has moved,
  // last winner for rotation, and the select left on the mux.
  int        m_owner = -1;
  int        m_beats = 0;
  int        m_ptr   = 3;
  int        m_sel   = 0;
  int        fix_c   = -1;
  logic [DW-1:0] m_data [4];

  task automatic drive_cycle(input logic [3:0] r, input logic [3:0] l,
                             input logic rdy, input logic rs);
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) m_data[i] = DW'($urandom);
    if (fix_c >= 0) m_data[2] = DW'(fix_c);
    req = r; last = l; out_ready = rdy; rst_n = rs;
    in_a = m_data[0]; in_b = m_data[1]; in_c = m_data[2]; in_d = m_data[3];

    e.busy  = (m_owner >= 0);
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.valid = (m_owner >= 0) && r[m_owner];
    e.data  = m_data[m_sel];
    e.beats = CW'(m_beats);
    exp_q.push_back(e);

    if (!rs) begin
      m_owner = -1; m_beats = 0; m_ptr = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0000) begin
        for (k = 1; k <= 4; k++) if (r[(m_ptr + k) % 4]) break;
        m_owner = (m_ptr + k) % 4;
        m_ptr = m_owner; m_sel = m_owner; m_beats = 0;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (rdy) begin
      m_beats++;
      if (l[m_owner] || m_beats == MAXB) m_owner = -1;
    end
  endtask

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt", int'(gnt), int'(e.gnt));
      check("mux_sel", int'(mux_sel), int'(e.sel));
      check("out_valid", int'(out_valid), int'(e.valid));
      check("busy", int'(busy), int'(e.busy));
      check("out_data", int'(out_data), int'(e.data));
      if (e.busy) check("beat_cnt", int'(dbg_beat_cnt), int'(e.beats));
    end
  end

  int seen_order[$];

  initial begin
    // Reset held with every source requesting, then fairness rotation.
    repeat (2) drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b1);
      if (m_owner >= 0 && (seen_order.size() == 0 || seen_order[$] != m_owner))
        seen_order.push_back(m_owner);
    end
    check("first_grant_after_reset", seen_order.size() > 0 ? seen_order[0] : -1, 0);
    check("rotation_b", seen_order.size() > 1 ? seen_order[1] : -1, 1);
    check("rotation_d_then_a", seen_order.size() > 4 ? seen_order[3] * 4 + seen_order[4] : -1, 12);

    // Single burst from C, last on the third beat.
    drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    fix_c = 8'h5A;
    for (int i = 0; i < 12; i++)
      drive_cycle(4'b0100, (m_owner == 2 && m_beats == 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b1);
    fix_c = -1;
    drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);

    // Max burst: A then B with no last.
    for (int i = 0; i < 40; i++) drive_cycle(4'b0011, 4'b0000, 1'b1, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);

    // Stall then withdrawal on B.
    drive_cycle(4'b0010, 4'b0000, 1'b1, 1'b1);
    drive_cycle(4'b0010, 4'b0000, 1'b1, 1'b1);
    repeat (4) drive_cycle(4'b0010, 4'b0000, 1'b0, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1);

    // Mid-burst reset during C, then A must win.
    for (int i = 0; i < 20 && !(m_owner == 2 && m_beats == 5); i++)
      drive_cycle(4'b0100, 4'b0000, 1'b1, 1'b1);
    drive_cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
    drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b1);
    check("grant_after_midburst_reset", m_owner, 0);
    repeat (3) drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      drive_cycle(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) != 0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
